// File: rtl/kernel_bc_start_consumer_ctrl_pkg.sv
// Shared types and defaults for the kernel_bc start-token consumer controller.
// Holds the FSM state enum, default widths and the watchdog width helper.
package kernel_bc_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } ctrl_state_e;

    localparam int DEF_DATA_WIDTH     = 1;
    localparam int DEF_MAX_INFLIGHT   = 2;
    localparam int DEF_CNT_WIDTH      = 3;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // The counter must be able to hold TIMEOUT_CYCLES itself.
    function automatic int wd_cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/kernel_bc_start_consumer_ctrl_if.sv
// Start-FIFO read side, process handshake and status bundle of the consumer controller.
// master: controller side; slave: FIFO/process/status environment.
interface kernel_bc_start_consumer_ctrl_if
    import kernel_bc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
    logic                  fifo_empty_n;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_read;
    logic                  ap_start;
    logic                  ap_ready;
    logic                  ap_done;
    logic                  ap_continue;
    logic                  cont_en;
    logic [DATA_WIDTH-1:0] token_q;
    logic [CNT_WIDTH-1:0]  inflight;
    logic                  done_pulse;
    logic                  ctrl_idle;
    logic                  timeout_err;

    modport master (
        input  fifo_empty_n, fifo_dout, ap_ready, ap_done, cont_en,
        output fifo_read, ap_start, ap_continue, token_q, inflight,
               done_pulse, ctrl_idle, timeout_err
    );

    modport slave (
        output fifo_empty_n, fifo_dout, ap_ready, ap_done, cont_en,
        input  fifo_read, ap_start, ap_continue, token_q, inflight,
               done_pulse, ctrl_idle, timeout_err
    );

endinterface

// File: rtl/kernel_bc_start_consumer_ctrl_inflight_cnt.sv
// Up/down in-flight invocation counter, saturating at 0 and MAX_VAL; 1-cycle update.
// Increment and decrement on the same edge cancel; full/empty are decoded from the register.
module kernel_bc_start_inflight_cnt #(
    parameter int CNT_WIDTH = 3,
    parameter int MAX_VAL   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_inc,
    input  logic                 i_dec,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_full,
    output logic                 o_empty
);
    localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(MAX_VAL);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_inc_ok;
    logic                 w_dec_ok;

    assign o_full   = (r_cnt >= LP_MAX);
    assign o_empty  = (r_cnt == '0);
    assign w_dec_ok = i_dec && !o_empty;
    // A completion on the same edge frees the slot the new issue needs.
    assign w_inc_ok = i_inc && (!o_full || w_dec_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_inc_ok && !w_dec_ok) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_inc_ok && w_dec_ok) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/kernel_bc_start_consumer_ctrl.sv
// Pops start tokens and drives one HLS process via ap_start/ap_ready/ap_done/ap_continue.
// Token-to-ap_start 1 cycle; pops stall while inflight==MAX_INFLIGHT or ap_start is pending.
// Optional watchdog: define KERNEL_BC_START_CTRL_TIMEOUT_EN.
module kernel_bc_start_consumer_ctrl
    import kernel_bc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int MAX_INFLIGHT   = DEF_MAX_INFLIGHT,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                            clk,
    input  logic                            reset_n,
    kernel_bc_start_consumer_ctrl_if.master bus
);
    ctrl_state_e           r_state;
    ctrl_state_e           w_state_nxt;
    logic                  w_pop;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_WIDTH-1:0]  w_cnt;
    logic [DATA_WIDTH-1:0] r_token;
    logic                  r_done_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capacity comes from the registered count, so a completion cannot enable a same-cycle pop.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.fifo_empty_n && !w_full) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.ap_ready) begin
                    w_inc       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_dec = bus.ap_done && bus.cont_en && !w_empty;

    kernel_bc_start_inflight_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .MAX_VAL   (MAX_INFLIGHT)
    ) u_inflight_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_cnt   (w_cnt),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_token      <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= w_dec;
            if (w_pop) begin
                r_token <= bus.fifo_dout;
            end
        end
    end

    // No pop may escape while reset is held, even though the FSM decodes IDLE.
    assign bus.fifo_read   = w_pop && reset_n;
    assign bus.ap_start    = (r_state == ISSUE);
    assign bus.ap_continue = bus.cont_en;
    assign bus.token_q     = r_token;
    assign bus.inflight    = w_cnt;
    assign bus.done_pulse  = r_done_pulse;
    assign bus.ctrl_idle   = (r_state == IDLE) && w_empty;

`ifdef KERNEL_BC_START_CTRL_TIMEOUT_EN
    localparam int LP_WD_W = wd_cnt_width(TIMEOUT_CYCLES);
    localparam logic [LP_WD_W-1:0] LP_WD_MAX = LP_WD_W'(TIMEOUT_CYCLES);

    logic [LP_WD_W-1:0] r_wd_cnt;
    logic               r_timeout_err;

    // r_wd_cnt counts completed ISSUE cycles; the flag is set on the edge that completes the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (r_state == ISSUE) begin
            if (r_wd_cnt != LP_WD_MAX) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (r_wd_cnt == LP_WD_MAX - 1'b1) begin
                r_timeout_err <= 1'b1;
            end
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    // Watchdog compiled out: the flag is a constant low.
    assign bus.timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_kernel_bc_start_consumer_ctrl.sv
// Self-checking bench for kernel_bc_start_consumer_ctrl: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a behavioural model.
module tb_kernel_bc_start_consumer_ctrl;
    import kernel_bc_ctrl_pkg::*;

    localparam int DW   = 4;
    localparam int MAXI = 2;
    localparam int CW   = 3;
    localparam int TO   = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    kernel_bc_start_consumer_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    kernel_bc_start_consumer_ctrl #(
        .DATA_WIDTH     (DW),
        .MAX_INFLIGHT   (MAXI),
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          en;
        logic [DW-1:0] dout;
        logic          rdy;
        logic          done;
        logic          cont;
        logic          x_read;
        logic          x_start;
        logic [DW-1:0] x_tok;
        logic [CW-1:0] x_infl;
        logic          x_dp;
        logic          x_idle;
    } vec_t;

    vec_t vt[16];

    // Behavioural model state
    bit            m_iss;
    int            m_infl;
    logic [DW-1:0] m_tok;
    bit            m_dp;
    int            m_wd;
    bit            m_err;

    function automatic vec_t mk(input logic en, input int dout, input logic rdy, input logic done,
                                input logic cont, input logic rd, input logic st, input int tok,
                                input int infl, input logic dp, input logic idle);
        vec_t v;
        v.en = en; v.dout = DW'(dout); v.rdy = rdy; v.done = done; v.cont = cont;
        v.x_read = rd; v.x_start = st; v.x_tok = DW'(tok); v.x_infl = CW'(infl);
        v.x_dp = dp; v.x_idle = idle;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic en, input logic [DW-1:0] dout, input logic rdy,
                          input logic done, input logic cont);
        bus.fifo_empty_n = en;
        bus.fifo_dout    = dout;
        bus.ap_ready     = rdy;
        bus.ap_done      = done;
        bus.cont_en      = cont;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_iss = 0; m_infl = 0; m_tok = '0; m_dp = 0; m_wd = 0; m_err = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_in(0, '0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_read"},  32'(bus.fifo_read),   0);
        chk({tag, "_start"}, 32'(bus.ap_start),    0);
        chk({tag, "_tok"},   32'(bus.token_q),     0);
        chk({tag, "_infl"},  32'(bus.inflight),    0);
        chk({tag, "_dp"},    32'(bus.done_pulse),  0);
        chk({tag, "_idle"},  32'(bus.ctrl_idle),   1);
        chk({tag, "_err"},   32'(bus.timeout_err), 0);
    endtask

    initial begin
        int pops;
        bit exp_err;
        bit pop, acc, comp;

        vt[0]  = mk(1, 1, 1, 0, 1,  1, 0, 0, 0, 0, 1);
        vt[1]  = mk(0, 0, 1, 0, 1,  0, 1, 1, 0, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 0);
        vt[3]  = mk(0, 0, 0, 1, 1,  0, 0, 1, 1, 0, 0);
        vt[4]  = mk(0, 0, 0, 0, 1,  0, 0, 1, 0, 1, 1);
        vt[5]  = mk(1, 5, 0, 0, 1,  1, 0, 1, 0, 0, 1);
        vt[6]  = mk(0, 0, 1, 0, 1,  0, 1, 5, 0, 0, 0);
        vt[7]  = mk(1, 9, 0, 0, 1,  1, 0, 5, 1, 0, 0);
        vt[8]  = mk(0, 0, 1, 1, 1,  0, 1, 9, 1, 0, 0);
        vt[9]  = mk(0, 0, 0, 0, 1,  0, 0, 9, 1, 1, 0);
        vt[10] = mk(0, 0, 0, 1, 0,  0, 0, 9, 1, 0, 0);
        vt[11] = mk(0, 0, 0, 0, 0,  0, 0, 9, 1, 0, 0);
        vt[12] = mk(0, 0, 0, 1, 1,  0, 0, 9, 1, 0, 0);
        vt[13] = mk(0, 0, 0, 0, 1,  0, 0, 9, 0, 1, 1);
        vt[14] = mk(0, 0, 0, 1, 1,  0, 0, 9, 0, 0, 1);
        vt[15] = mk(0, 0, 0, 0, 0,  0, 0, 9, 0, 0, 1);

        // Reset state
        set_in(0, '0, 0, 0, 0);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed table: single token, simultaneous accept/complete, cont_en=0, done at zero
        for (int i = 0; i < 16; i++) begin
            set_in(vt[i].en, vt[i].dout, vt[i].rdy, vt[i].done, vt[i].cont);
            #3;
            chk($sformatf("vec%0d_read", i),  32'(bus.fifo_read),   32'(vt[i].x_read));
            chk($sformatf("vec%0d_start", i), 32'(bus.ap_start),    32'(vt[i].x_start));
            chk($sformatf("vec%0d_tok", i),   32'(bus.token_q),     32'(vt[i].x_tok));
            chk($sformatf("vec%0d_infl", i),  32'(bus.inflight),    32'(vt[i].x_infl));
            chk($sformatf("vec%0d_dp", i),    32'(bus.done_pulse),  32'(vt[i].x_dp));
            chk($sformatf("vec%0d_idle", i),  32'(bus.ctrl_idle),   32'(vt[i].x_idle));
            chk($sformatf("vec%0d_cont", i),  32'(bus.ap_continue), 32'(vt[i].cont));
            next_cycle();
        end

        // Backpressure: FIFO always non-empty, ready high, no completions
        do_reset();
        set_in(1, 4'h3, 1, 0, 1);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (bus.fifo_read === 1'b1) pops++;
            next_cycle();
        end
        #3;
        chk("bp_pops", 32'(pops), 2);
        chk("bp_infl_full", 32'(bus.inflight), 2);
        chk("bp_read_held", 32'(bus.fifo_read), 0);
        bus.ap_done = 1'b1;
        #0;
        chk("bp_no_pop_on_done", 32'(bus.fifo_read), 0);
        next_cycle();
        bus.ap_done = 1'b0;
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (bus.fifo_read === 1'b1) pops++;
            next_cycle();
        end
        #3;
        chk("bp_refill_pops", 32'(pops), 1);
        chk("bp_refill_infl", 32'(bus.inflight), 2);

        // Stalled ready, watchdog, then reset in the middle of ISSUE
        do_reset();
        set_in(1, 4'h7, 0, 0, 1);
        #3;
        chk("stall_pop", 32'(bus.fifo_read), 1);
        next_cycle();
        for (int k = 1; k <= 10; k++) begin
            #3;
            chk($sformatf("stall%0d_start", k), 32'(bus.ap_start), 1);
            chk($sformatf("stall%0d_read", k), 32'(bus.fifo_read), 0);
`ifdef KERNEL_BC_START_CTRL_TIMEOUT_EN
            chk($sformatf("stall%0d_err", k), 32'(bus.timeout_err), (k >= 9) ? 1 : 0);
`endif
            next_cycle();
        end
        bus.ap_ready = 1'b1;
        #3;
        chk("stall_release_start", 32'(bus.ap_start), 1);
        next_cycle();
        bus.ap_ready = 1'b0;
        #3;
        chk("stall_drop_start", 32'(bus.ap_start), 0);
        chk("stall_infl", 32'(bus.inflight), 1);
        chk("stall_tok", 32'(bus.token_q), 7);
`ifdef KERNEL_BC_START_CTRL_TIMEOUT_EN
        chk("wd_sticky", 32'(bus.timeout_err), 1);
`endif
        next_cycle();
        #1;
        chk("rst_mid_pre_start", 32'(bus.ap_start), 1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        next_cycle();
        reset_n = 1'b1;
        set_in(0, '0, 0, 0, 0);
        next_cycle();

        // Randomized run against the behavioural model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            set_in(($urandom_range(0, 1) == 1), DW'($urandom), ($urandom_range(0, 9) < 6),
                   ($urandom_range(0, 9) < 4), ($urandom_range(0, 3) != 0));
            #3;
            pop  = !m_iss && bus.fifo_empty_n && (m_infl < MAXI);
            acc  = m_iss && bus.ap_ready;
            comp = bus.ap_done && bus.cont_en && (m_infl > 0);
`ifdef KERNEL_BC_START_CTRL_TIMEOUT_EN
            exp_err = m_err;
`else
            exp_err = 1'b0;
`endif
            chk("rnd_read",  32'(bus.fifo_read),   32'(pop));
            chk("rnd_start", 32'(bus.ap_start),    32'(m_iss));
            chk("rnd_tok",   32'(bus.token_q),     32'(m_tok));
            chk("rnd_infl",  32'(bus.inflight),    32'(m_infl));
            chk("rnd_dp",    32'(bus.done_pulse),  32'(m_dp));
            chk("rnd_idle",  32'(bus.ctrl_idle),   32'(!m_iss && m_infl == 0));
            chk("rnd_cont",  32'(bus.ap_continue), 32'(bus.cont_en));
            chk("rnd_err",   32'(bus.timeout_err), 32'(exp_err));
            if (m_iss) begin
                m_wd++;
                if (m_wd >= TO) m_err = 1;
            end else begin
                m_wd = 0;
            end
            m_infl = m_infl + int'(acc) - int'(comp);
            m_dp   = comp;
            if (pop) m_tok = bus.fifo_dout;
            if (pop) m_iss = 1;
            else if (acc) m_iss = 0;
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: simulation did not reach its summary in time");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule

// File: doc/kernel_bc_start_consumer_ctrl.md
# kernel_bc_start_consumer_ctrl

Consumer-side controller for a dataflow start-token channel in the kernel_bc design. It pops start tokens from the read port of a start FIFO (the producer has already pushed them) and drives one downstream HLS process through its ap_start/ap_ready/ap_done/ap_continue handshake. It tracks how many invocations are in flight and reports each completion. It sits between the start FIFO's read side and the consumer process block.

## Interface
Parameters:
- DATA_WIDTH, 1, start-token width (same as the start FIFO data width)
- MAX_INFLIGHT, 2, maximum issued-but-not-done invocations (1..7)
- CNT_WIDTH, 3, in-flight counter width; must hold MAX_INFLIGHT
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the macro)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- fifo_empty_n  in  1  start FIFO has a token; fifo_dout is valid (first-word-fall-through)
- fifo_dout  in  DATA_WIDTH  token at the FIFO head
- fifo_read  out  1  pop strobe, combinational
- ap_start  out  1  start request to the process
- ap_ready  in  1  process accepted the start
- ap_done  in  1  process finished one invocation
- ap_continue  out  1  done acknowledge, equal to cont_en
- cont_en  in  1  downstream allows completion acknowledge
- token_q  out  DATA_WIDTH  token of the most recent issue
- inflight  out  CNT_WIDTH  current in-flight count
- done_pulse  out  1  one-cycle pulse per acknowledged completion
- ctrl_idle  out  1  state is IDLE and inflight is 0
- timeout_err  out  1  sticky watchdog flag

## Operation
- States:
  - IDLE: waiting for a token and for in-flight capacity.
  - ISSUE: ap_start is held high.
- IDLE → ISSUE:
  - Transition when fifo_empty_n=1 and inflight < MAX_INFLIGHT.
  - fifo_read=1 in that same cycle.
  - token_q <= fifo_dout at the same edge.
- ISSUE → IDLE:
  - Transition on the edge where ap_ready=1.
  - inflight increments at that edge.
- ap_start = (state==ISSUE).
  - It is registered and stays high until ap_ready is sampled.
  - It never drops while ap_ready is low.
- Completion: a cycle with ap_done=1 and cont_en=1.
  - inflight decrements.
  - done_pulse=1 in the following cycle.
- Simultaneous increment and completion: inflight is unchanged and done_pulse still fires.
- Never decrement below 0. An ap_done with inflight=0 is ignored and produces no pulse.
- fifo_read is never asserted while fifo_empty_n=0, and never in ISSUE.
- inflight == MAX_INFLIGHT:
  - Stay in IDLE and do not pop the FIFO.
  - A completion in that cycle does not allow a pop in the same cycle; the pop happens the next cycle at the earliest.

## Timing
- Reset values (asynchronous, applied immediately on reset_n=0):
  - state=IDLE, ap_start=0, fifo_read=0, token_q=0, inflight=0, done_pulse=0, ctrl_idle=1, timeout_err=0.
- Reset during ISSUE: ap_start drops asynchronously and the token is discarded. The FIFO is not re-read.
- Token-to-start latency:
  - Token visible in cycle 0 → fifo_read in cycle 0 → ap_start high from cycle 1.
- Issue rate:
  - With ap_ready already high, ap_start is high for exactly one cycle.
  - Minimum spacing between accepted starts is 2 cycles (one IDLE bubble).
- ap_continue is purely combinational from cont_en.
- done_pulse is registered and lags the completing edge by 1 cycle.

## Configuration
- Macro KERNEL_BC_START_CTRL_TIMEOUT_EN defined:
  - A counter runs while in ISSUE and clears on leaving ISSUE.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set.
  - timeout_err stays set until reset. Functional behaviour is otherwise unchanged.
- Macro undefined:
  - No counter exists and timeout_err is tied to 0.

## Structure
- Shared package kernel_bc_ctrl_pkg contains:
  - the state enum (IDLE, ISSUE);
  - the default width constants;
  - the watchdog counter width function clog2(TIMEOUT_CYCLES+1).
- One natural sub-module, kernel_bc_start_inflight_cnt:
  - an up/down saturating counter with inc/dec/full/empty outputs;
  - instantiated once.
- The FSM and the token register live in the top module.

## Test plan
- Single token:
  - Stimulus: fifo_dout=1 and fifo_empty_n=1 for one cycle; ap_ready=1.
  - Expect: fifo_read in cycle 0, ap_start in cycle 1 only, token_q=1, inflight=1.
  - Then ap_done with cont_en=1 → inflight=0, done_pulse one cycle later, ctrl_idle=1.
- Backpressure:
  - Stimulus: MAX_INFLIGHT=2, FIFO always non-empty, ap_ready=1, no ap_done.
  - Expect: exactly 2 pops, then fifo_read stays 0 and inflight=2 indefinitely.
  - Then one ap_done → exactly one further pop.
- Stalled ready:
  - Stimulus: hold ap_ready=0 for 10 cycles.
  - Expect: ap_start stays high all 10 cycles with no extra fifo_read; it drops the cycle after ap_ready=1.
- Simultaneous events:
  - Stimulus: ap_ready and ap_done (cont_en=1) on the same edge with inflight=1.
  - Expect: inflight stays 1 and done_pulse=1.
- cont_en=0:
  - Expect: ap_done is ignored, inflight is unchanged, no done_pulse.
- Reset and watchdog:
  - Drop reset_n mid-ISSUE → ap_start=0 immediately, all outputs at reset values.
  - With the macro defined and TIMEOUT_CYCLES=8, hold ap_ready=0 → timeout_err rises after 8 ISSUE cycles and stays set until reset.
